// File: rtl/gact_job_driver.sv
// gact_job_driver: host-side initiator for the GACT systolic alignment core.
// A serial stream of 2-bit bases (R_LEN reference bases, then Q_LEN query
// bases) is packed into the core's parallel R/Q words. The driver then fires a
// one-cycle launch pulse, waits for done or watchdog expiry, and presents the
// score on a result port.
//
// Handshake semantics (both the base input and the result output):
//   A transfer happens on a rising clk edge where valid && ready are both high.
//   A producer holding valid keeps its payload stable until that edge. The
//   result side never withdraws res_valid, res_score or res_timeout before the
//   transfer. base_valid while base_ready is low is simply not consumed.
module gact_job_driver #(
  parameter int R_LEN          = 128,
  parameter int Q_LEN          = 128,
  parameter int SCORE_BITS     = 12,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            base_in,
  input  logic                  base_valid,
  output logic                  base_ready,
  output logic [2*R_LEN-1:0]    gact_R,
  output logic [2*Q_LEN-1:0]    gact_Q,
  output logic                  gact_valid,
  input  logic                  gact_done,
  input  logic [SCORE_BITS-1:0] gact_score,
  output logic [SCORE_BITS-1:0] res_score,
  output logic                  res_timeout,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic                  busy
);

  // Index counter spans the longer of the two loads; the watchdog must be able
  // to hold TIMEOUT_CYCLES itself so it never wraps.
  localparam int IDX_MAX = (R_LEN > Q_LEN) ? R_LEN : Q_LEN;
  localparam int IDX_W   = (IDX_MAX > 1) ? $clog2(IDX_MAX) : 1;
  localparam int WD_W    = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [IDX_W-1:0] R_LAST  = IDX_W'(R_LEN - 1);
  localparam logic [IDX_W-1:0] Q_LAST  = IDX_W'(Q_LEN - 1);
  localparam logic [WD_W-1:0]  WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_LOAD_R = 3'd0,
    ST_LOAD_Q = 3'd1,
    ST_LAUNCH = 3'd2,
    ST_WAIT   = 3'd3,
    ST_RESULT = 3'd4
  } state_t;

  // Current and next FSM state; kept as named signals so checkers can bind.
  state_t state;
  state_t state_next;

  logic [IDX_W-1:0] idx;
  logic [WD_W-1:0]  wdog;
  logic             xfer;
  logic             idx_last;
  logic             wd_expired;
  logic             gact_valid_q;

  assign xfer       = base_valid && base_ready;
  assign wd_expired = (wdog == WD_LAST);
  assign gact_valid = gact_valid_q;

  // Last-base detection depends on which word is being filled.
  always_comb begin
    idx_last = 1'b0;
    case (state)
      ST_LOAD_R: idx_last = (idx == R_LAST);
      ST_LOAD_Q: idx_last = (idx == Q_LAST);
      default:   idx_last = 1'b0;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_LOAD_R;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. Done takes priority over the watchdog in WAIT.
  always_comb begin
    state_next = state;
    case (state)
      ST_LOAD_R: if (xfer && idx_last) state_next = ST_LOAD_Q;
      ST_LOAD_Q: if (xfer && idx_last) state_next = ST_LAUNCH;
      ST_LAUNCH: state_next = ST_WAIT;
      ST_WAIT:   if (gact_done || wd_expired) state_next = ST_RESULT;
      ST_RESULT: if (res_ready) state_next = ST_LOAD_R;
      default:   state_next = ST_LOAD_R;
    endcase
  end

  // Output decode: only the loading states take bases, only RESULT offers one.
  always_comb begin
    base_ready = 1'b0;
    res_valid  = 1'b0;
    case (state)
      ST_LOAD_R: base_ready = 1'b1;
      ST_LOAD_Q: base_ready = 1'b1;
      ST_RESULT: res_valid  = 1'b1;
      default: begin
        base_ready = 1'b0;
        res_valid  = 1'b0;
      end
    endcase
    busy = !((state == ST_LOAD_R) && (idx == '0));
  end

  // Launch pulse is registered so the core sees a clean one-cycle strobe,
  // high exactly while the FSM sits in LAUNCH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gact_valid_q <= 1'b0;
    end else begin
      gact_valid_q <= (state_next == ST_LAUNCH);
    end
  end

  // Base index: advances per accepted base, clears after each word completes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx <= '0;
    end else if (xfer) begin
      if (idx_last) begin
        idx <= '0;
      end else begin
        idx <= idx + IDX_W'(1);
      end
    end
  end

  // Packing: base k lands at bits [2k+1:2k] so base 0 is the LSB pair, which
  // the core consumes first as it shifts R right. Words are only written on
  // transfers, so they stay stable from LAUNCH until the next job's first base.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gact_R <= '0;
      gact_Q <= '0;
    end else if (xfer) begin
      if (state == ST_LOAD_R) begin
        gact_R[{idx, 1'b0} +: 2] <= base_in;
      end else if (state == ST_LOAD_Q) begin
        gact_Q[{idx, 1'b0} +: 2] <= base_in;
      end
    end
  end

  // Watchdog: cleared at launch, counts every WAIT cycle, saturates elsewhere.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wdog <= '0;
    end else if (state == ST_LAUNCH) begin
      wdog <= '0;
    end else if ((state == ST_WAIT) && !wd_expired) begin
      wdog <= wdog + WD_W'(1);
    end
  end

  // Result capture: done wins over a simultaneous watchdog expiry. Values are
  // only touched in WAIT, so they hold through RESULT backpressure.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      res_score   <= '0;
      res_timeout <= 1'b0;
    end else if (state == ST_WAIT) begin
      if (gact_done) begin
        res_score   <= gact_score;
        res_timeout <= 1'b0;
      end else if (wd_expired) begin
        res_score   <= '0;
        res_timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_gact_job_driver.sv
// Directed testbench for gact_job_driver: packing, launch timing, completion,
// result backpressure, watchdog timeout, input gaps, stray done, mid-job reset.
module tb_gact_job_driver;

  localparam int R_LEN = 128;
  localparam int Q_LEN = 128;
  localparam int SB    = 12;
  localparam int T     = 1023;

  logic                 clk;
  logic                 reset;
  logic [1:0]           base_in;
  logic                 base_valid;
  logic                 base_ready;
  logic [2*R_LEN-1:0]   gact_R;
  logic [2*Q_LEN-1:0]   gact_Q;
  logic                 gact_valid;
  logic                 gact_done;
  logic [SB-1:0]        gact_score;
  logic [SB-1:0]        res_score;
  logic                 res_timeout;
  logic                 res_valid;
  logic                 res_ready;
  logic                 busy;

  gact_job_driver #(
    .R_LEN(R_LEN), .Q_LEN(Q_LEN), .SCORE_BITS(SB), .TIMEOUT_CYCLES(T)
  ) dut (
    .clk(clk), .reset(reset),
    .base_in(base_in), .base_valid(base_valid), .base_ready(base_ready),
    .gact_R(gact_R), .gact_Q(gact_Q), .gact_valid(gact_valid),
    .gact_done(gact_done), .gact_score(gact_score),
    .res_score(res_score), .res_timeout(res_timeout),
    .res_valid(res_valid), .res_ready(res_ready), .busy(busy)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  logic [1:0]         r_b [R_LEN];
  logic [1:0]         q_b [Q_LEN];
  logic [2*R_LEN-1:0] exp_r;
  logic [2*Q_LEN-1:0] exp_qw;
  logic [SB-1:0]      exp_q[$];   // expected scores, in result order
  logic [SB-1:0]      exp_score;

  // Single comparison point
  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference packing model: base k at bits [2k+1:2k]
  task automatic build_exp();
    for (int k = 0; k < R_LEN; k++) exp_r[2*k +: 2] = r_b[k];
    for (int k = 0; k < Q_LEN; k++) exp_qw[2*k +: 2] = q_b[k];
  endtask

  // Driver: one base, optionally preceded by random idle cycles
  task automatic send_base(input logic [1:0] b, input int gap_max);
    int g;
    g = (gap_max > 0) ? $urandom_range(0, gap_max) : 0;
    repeat (g) begin
      base_valid = 1'b0;
      base_in    = 2'($urandom_range(0, 3));
      @(negedge clk);
    end
    base_valid = 1'b1;
    base_in    = b;
    @(negedge clk);
    base_valid = 1'b0;
  endtask

  // Driver: first n bases of the current job; stray done during Q base stray_at
  task automatic load_job(input int n, input int gap_max, input int stray_at);
    for (int i = 0; i < n; i++) begin
      if (i < R_LEN) begin
        send_base(r_b[i], gap_max);
      end else begin
        gact_done = ((i - R_LEN) == stray_at);
        send_base(q_b[i - R_LEN], gap_max);
        if (gact_done) begin
          gact_done = 1'b0;
          chk("stray_done_res_valid", 256'(res_valid), 256'(0));
          chk("stray_done_base_ready", 256'(base_ready), 256'(1));
        end
      end
    end
  endtask

  // Launch check in the cycle after the last Q base; leaves us one cycle later
  task automatic check_launch(input string tag);
    chk({tag, "_gact_valid"}, 256'(gact_valid), 256'(1));
    chk({tag, "_gact_R"}, 256'(gact_R), 256'(exp_r));
    chk({tag, "_gact_Q"}, 256'(gact_Q), 256'(exp_qw));
    chk({tag, "_base_ready"}, 256'(base_ready), 256'(0));
    @(negedge clk);
    chk({tag, "_gact_valid_1cyc"}, 256'(gact_valid), 256'(0));
  endtask

  // Result check against the scoreboard head
  task automatic check_result(input string tag, input logic exp_to);
    if (exp_q.size() == 0) begin
      n_assert++;
      n_fail++;
      $error("FAIL %s_scoreboard: observed empty queue expected entry", tag);
    end else begin
      exp_score = exp_q.pop_front();
      chk({tag, "_res_valid"}, 256'(res_valid), 256'(1));
      chk({tag, "_res_score"}, 256'(res_score), 256'(exp_score));
      chk({tag, "_res_timeout"}, 256'(res_timeout), 256'(exp_to));
    end
  endtask

  // Result handshake, then ready for the next job in the following cycle
  task automatic accept_result(input string tag);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk({tag, "_hs_res_valid"}, 256'(res_valid), 256'(0));
    chk({tag, "_hs_base_ready"}, 256'(base_ready), 256'(1));
    chk({tag, "_hs_busy"}, 256'(busy), 256'(0));
  endtask

  task automatic check_idle_zero(input string tag);
    chk({tag, "_gact_R"}, 256'(gact_R), 256'(0));
    chk({tag, "_gact_Q"}, 256'(gact_Q), 256'(0));
    chk({tag, "_gact_valid"}, 256'(gact_valid), 256'(0));
    chk({tag, "_res_valid"}, 256'(res_valid), 256'(0));
    chk({tag, "_res_timeout"}, 256'(res_timeout), 256'(0));
    chk({tag, "_res_score"}, 256'(res_score), 256'(0));
    chk({tag, "_busy"}, 256'(busy), 256'(0));
  endtask

  initial begin
    int n;
    int bad;
    logic [2*R_LEN-1:0] r_hold;

    reset      = 1'b1;
    base_in    = 2'd0;
    base_valid = 1'b0;
    gact_done  = 1'b0;
    gact_score = '0;
    res_ready  = 1'b0;
    repeat (3) @(negedge clk);
    check_idle_zero("reset");
    reset = 1'b0;
    @(negedge clk);
    chk("post_reset_base_ready", 256'(base_ready), 256'(1));
    chk("post_reset_busy", 256'(busy), 256'(0));

    // Job 1: R = 0,1,2,3 repeating, Q = all 3
    for (int k = 0; k < R_LEN; k++) r_b[k] = 2'(k % 4);
    for (int k = 0; k < Q_LEN; k++) q_b[k] = 2'd3;
    build_exp();
    chk("pack_model_R", 256'(exp_r), {64{8'hE4}});
    load_job(R_LEN + Q_LEN, 0, -1);
    check_launch("job1");
    // Bases offered during WAIT must not be consumed
    r_hold     = gact_R;
    base_valid = 1'b1;
    base_in    = 2'd2;
    bad        = 0;
    repeat (258) begin
      @(negedge clk);
      if (base_ready !== 1'b0 || res_valid !== 1'b0) bad++;
    end
    base_valid = 1'b0;
    chk("wait_no_ready_cycles", 256'(bad), 256'(0));
    chk("wait_R_stable", 256'(gact_R), 256'(r_hold));
    // Done 260 cycles after launch
    gact_done  = 1'b1;
    gact_score = 12'h0FE;
    exp_q.push_back(12'h0FE);
    @(negedge clk);
    gact_done  = 1'b0;
    gact_score = 12'hABC;
    check_result("job1", 1'b0);
    // Backpressure: 50 cycles with res_ready low
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      chk("bp_res_valid", 256'(res_valid), 256'(1));
      chk("bp_res_score", 256'(res_score), 256'(12'h0FE));
      chk("bp_base_ready", 256'(base_ready), 256'(0));
    end
    accept_result("job1");

    // Job 2: random bases with gaps, stray done mid-Q, no done -> timeout
    for (int k = 0; k < R_LEN; k++) r_b[k] = 2'($urandom_range(0, 3));
    for (int k = 0; k < Q_LEN; k++) q_b[k] = 2'($urandom_range(0, 3));
    build_exp();
    load_job(R_LEN + Q_LEN, 3, 50);
    check_launch("job2");
    n = 1;
    while (!res_valid && n < T + 20) begin
      @(negedge clk);
      n++;
    end
    chk("timeout_latency", 256'(n), 256'(T + 1));
    exp_q.push_back(12'h000);
    check_result("job2_timeout", 1'b1);
    accept_result("job2");

    // Job 3: done on the final WAIT cycle wins over the watchdog
    for (int k = 0; k < R_LEN; k++) r_b[k] = 2'(3 - (k % 4));
    for (int k = 0; k < Q_LEN; k++) q_b[k] = 2'((k / 3) % 4);
    build_exp();
    load_job(R_LEN + Q_LEN, 1, -1);
    check_launch("job3");
    repeat (T - 1) @(negedge clk);
    chk("last_wait_res_valid", 256'(res_valid), 256'(0));
    gact_done  = 1'b1;
    gact_score = 12'd7;
    exp_q.push_back(12'd7);
    @(negedge clk);
    gact_done  = 1'b0;
    gact_score = 12'hABC;
    check_result("job3_late_done", 1'b0);
    accept_result("job3");

    // Job 4: reset after 200 bases discards the partial job
    for (int k = 0; k < R_LEN; k++) r_b[k] = 2'd1;
    for (int k = 0; k < Q_LEN; k++) q_b[k] = 2'd2;
    load_job(200, 0, -1);
    chk("partial_busy", 256'(busy), 256'(1));
    reset = 1'b1;
    #1;
    check_idle_zero("mid_reset");
    @(negedge clk);
    reset = 1'b0;

    // Job 5: full random job after reset loads from bit 0
    for (int k = 0; k < R_LEN; k++) r_b[k] = 2'($urandom_range(0, 3));
    for (int k = 0; k < Q_LEN; k++) q_b[k] = 2'($urandom_range(0, 3));
    build_exp();
    @(negedge clk);
    load_job(R_LEN + Q_LEN, 0, -1);
    check_launch("job5");
    repeat (4) @(negedge clk);
    gact_done  = 1'b1;
    gact_score = 12'h123;
    exp_q.push_back(12'h123);
    @(negedge clk);
    gact_done = 1'b0;
    check_result("job5", 1'b0);
    accept_result("job5");

    // Final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  // Global time limit so the run always ends
  initial begin
    #2000000;
    $display("FAIL global_timeout: observed time limit reached expected test completion");
    $fatal(1, "simulation time limit");
  end

endmodule

// File: doc/gact_job_driver.md
Name: gact_job_driver

Overview:
- Host-side initiator for the GACT systolic alignment core.
- Accepts a serial stream of 2-bit bases: R_LEN reference bases, then Q_LEN query bases.
- Packs them into the core's parallel R/Q words and issues a single-cycle launch pulse.
- Waits for the core's done, captures the score, and returns it on a valid/ready result port, with a watchdog timeout.

Parameters:
R_LEN, 128, reference length in bases
Q_LEN, 128, query length in bases
SCORE_BITS, 12, score width
TIMEOUT_CYCLES, 1023, maximum WAIT cycles before abort (must exceed 2*Q_LEN+4)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
base_in  input  2  base code (A/C/G/T = 0..3)
base_valid  input  1  base_in valid
base_ready  output  1  driver accepts a base this cycle
gact_R  output  2*R_LEN  packed reference to core
gact_Q  output  2*Q_LEN  packed query to core
gact_valid  output  1  one-cycle launch pulse to core
gact_done  input  1  core completion pulse
gact_score  input  SCORE_BITS  core score, sampled with gact_done
res_score  output  SCORE_BITS  captured score
res_timeout  output  1  result produced by watchdog, not by done
res_valid  output  1  result available
res_ready  input  1  result consumer ready
busy  output  1  high in any state other than LOAD_R with index 0

Behaviour:
- One clock; reset is asynchronous and active-high.
- Reset values:
  - state = LOAD_R; base index = 0; watchdog = 0.
  - gact_R = 0; gact_Q = 0.
  - gact_valid = 0; res_valid = 0; res_timeout = 0; res_score = 0; busy = 0.
- Base transfer: occurs on any edge with base_valid && base_ready.
- FSM states: LOAD_R, LOAD_Q, LAUNCH, WAIT, RESULT.
- LOAD_R:
  - base_ready = 1.
  - Base k (k = 0..R_LEN-1, arrival order) is written to gact_R[2k+1:2k]. Base 0 sits at bits [1:0] because the core shifts R right.
  - After the transfer with k = R_LEN-1: index clears and state goes to LOAD_Q.
- LOAD_Q:
  - base_ready = 1.
  - Base k is written to gact_Q[2k+1:2k].
  - After k = Q_LEN-1: go to LAUNCH.
- LAUNCH:
  - base_ready = 0; gact_valid = 1 for exactly this one cycle (registered output).
  - Next state is WAIT; watchdog clears.
  - gact_R/gact_Q stay stable from LAUNCH until the next LOAD_R write. The core latches them on the launch edge.
- WAIT:
  - base_ready = 0; watchdog increments each cycle.
  - gact_done = 1: res_score <= gact_score, res_timeout <= 0, then RESULT.
  - Watchdog reaches TIMEOUT_CYCLES-1 without done: res_score <= 0, res_timeout <= 1, then RESULT.
  - done and timeout in the same cycle: done wins.
- RESULT:
  - res_valid = 1; res_score and res_timeout held stable until res_valid && res_ready.
  - On the handshake: res_valid drops next cycle and state goes to LOAD_R, so base_ready = 1 that cycle. No bubble beyond that.
- gact_done outside WAIT is ignored; no state change, no capture.
- Latency:
  - Last Q base accepted at edge E: gact_valid is high during the cycle after E.
  - done sampled at edge D: res_valid is high the cycle after D.
- Minimum relaunch spacing is guaranteed by the reload length (≥ R_LEN+Q_LEN cycles). The core is always back in idle before the next pulse.
- base_valid while base_ready = 0: no effect; the base is not consumed.
- Index counter width: clog2(max(R_LEN,Q_LEN)). Watchdog width: clog2(TIMEOUT_CYCLES+1). No wrap is permitted in either.
- Reset asserted mid-operation (any state): everything returns to reset values immediately. A partially loaded job is discarded. A pending result is lost.

Test Plan:
- Packing: R bases repeating 0,1,2,3 and Q all 3 → gact_R = 256'hE4E4…E4, gact_Q = all ones at LAUNCH; gact_valid high exactly 1 cycle, 1 cycle after last Q base.
- Normal completion: responder pulses gact_done with gact_score = 12'h0FE 260 cycles after launch → res_valid next cycle, res_score = 0x0FE, res_timeout = 0.
- Backpressure:
  - res_ready held low 50 cycles → res_valid/res_score stable and base_ready = 0 throughout.
  - Handshake → base_ready = 1 next cycle.
- Timeout: no gact_done → res_valid after exactly TIMEOUT_CYCLES WAIT cycles, res_timeout = 1, res_score = 0. With done on the final WAIT cycle and gact_score = 7 → res_score = 7, res_timeout = 0.
- Input gaps and stray done:
  - base_valid toggled randomly during load → no bases lost or duplicated; packed words match the reference.
  - gact_done pulsed during LOAD_Q → ignored.
- Reset at base 200 of a job → all outputs zero. Next full 256-base job loads from bit 0 and launches correctly.
